// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
interface instr_fetch_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned IW = 16
);
  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic          mem_ack;
  logic [IW-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_req,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_req,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: samples pc, runs a req/ack read with timeout, and holds the result in the IR.
// Optional FETCH_STATS_EN adds saturating fetch/stall counters.
module instr_fetch #(
  parameter int unsigned IW      = 16,
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     pc,
  input  logic              fetch_start,
  input  logic              flush,
  instr_fetch_if.master     mem,
  output logic [IW-1:0]     ir,
  output logic              ir_valid,
  output logic [AW-1:0]     jump_instr,
  output logic              fetch_busy,
  output logic              fetch_err
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          valid_d = 1'b0;
        end else if (fetch_start) begin
          addr_d  = pc;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        // Flush wins over a same-cycle ack: the returned word is dropped.
        if (flush) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          valid_d = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          ir_d    = '0;
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem.mem_addr = addr_q;
  assign mem.mem_req  = (state_q == StReq);
  assign fetch_busy   = (state_q == StReq);
  assign ir           = ir_q;
  assign ir_valid     = valid_q;
  assign jump_instr   = ir_q[AW-1:0];
  assign fetch_err    = err_q;

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, stall_cnt_q;
  logic        load_evt, stall_evt;

  assign load_evt  = (state_q == StReq) && mem.mem_ack && !flush;
  assign stall_evt = (state_q == StReq) && !mem.mem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load_evt && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (stall_evt && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table plus hand sequences for timeout, reset and
// back-to-back fetches.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc;
  logic        fetch_start;
  logic        flush;
  logic [15:0] ir;
  logic        ir_valid;
  logic [7:0]  jump_instr;
  logic        fetch_busy;
  logic        fetch_err;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt, stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_if #(.AW(8), .IW(16)) bus ();

  instr_fetch #(.IW(16), .AW(8), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .fetch_start(fetch_start),
    .flush      (flush),
    .mem        (bus),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .jump_instr (jump_instr),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        fs;
    logic        fl;
    logic [7:0]  pc;
    logic        ack;
    logic [15:0] rdata;
    logic [15:0] e_ir;
    logic        e_v;
    logic        e_req;
    logic [7:0]  e_addr;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too, half a cycle after
  // the rising edge that produced them.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fetch_start   = 1'b0;
    flush         = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
  endtask

  int          err_at;
  int          n;
  logic [7:0]  addrs[3];
  logic [15:0] word;
`ifdef FETCH_STATS_EN
  logic [15:0] stall0, fetch0;
`endif

  initial begin
    //         fs    fl    pc     ack   rdata     e_ir      e_v   e_req e_addr
    vecs[0] = '{1'b1, 1'b0, 8'h05, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'h05};
    vecs[1] = '{1'b0, 1'b0, 8'h06, 1'b1, 16'hA30C, 16'hA30C, 1'b1, 1'b0, 8'h05};
    vecs[2] = '{1'b0, 1'b0, 8'h07, 1'b1, 16'h5555, 16'hA30C, 1'b1, 1'b0, 8'h05};
    vecs[3] = '{1'b0, 1'b0, 8'h08, 1'b0, 16'h0000, 16'hA30C, 1'b1, 1'b0, 8'h05};
    vecs[4] = '{1'b1, 1'b0, 8'h10, 1'b0, 16'h0000, 16'hA30C, 1'b0, 1'b1, 8'h10};
    vecs[5] = '{1'b0, 1'b1, 8'h11, 1'b1, 16'hFFFF, 16'hA30C, 1'b0, 1'b0, 8'h10};
    vecs[6] = '{1'b1, 1'b1, 8'h20, 1'b0, 16'h0000, 16'hA30C, 1'b0, 1'b0, 8'h10};
    vecs[7] = '{1'b1, 1'b0, 8'hFF, 1'b0, 16'h0000, 16'hA30C, 1'b0, 1'b1, 8'hFF};
    vecs[8] = '{1'b1, 1'b0, 8'h33, 1'b1, 16'h7E42, 16'h7E42, 1'b1, 1'b0, 8'hFF};
    vecs[9] = '{1'b0, 1'b1, 8'h34, 1'b0, 16'h0000, 16'h7E42, 1'b0, 1'b0, 8'hFF};
    addrs[0] = 8'hFE;
    addrs[1] = 8'hFF;
    addrs[2] = 8'h00;

    rst = 1'b1;
    pc  = 8'h00;
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    check("reset ir", 32'(ir), 32'h0);
    check("reset ir_valid", 32'(ir_valid), 32'h0);
    check("reset mem_req", 32'(bus.mem_req), 32'h0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'h0);
    check("reset fetch_busy", 32'(fetch_busy), 32'h0);
    check("reset fetch_err", 32'(fetch_err), 32'h0);
    check("reset jump_instr", 32'(jump_instr), 32'h0);
    tick();
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      fetch_start   = vecs[i].fs;
      flush         = vecs[i].fl;
      pc            = vecs[i].pc;
      bus.mem_ack   = vecs[i].ack;
      bus.mem_rdata = vecs[i].rdata;
      tick();
      check($sformatf("vec%0d ir", i), 32'(ir), 32'(vecs[i].e_ir));
      check($sformatf("vec%0d ir_valid", i), 32'(ir_valid), 32'(vecs[i].e_v));
      check($sformatf("vec%0d mem_req", i), 32'(bus.mem_req), 32'(vecs[i].e_req));
      check($sformatf("vec%0d fetch_busy", i), 32'(fetch_busy), 32'(vecs[i].e_req));
      check($sformatf("vec%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d jump_instr", i), 32'(jump_instr), 32'(vecs[i].e_ir[7:0]));
      check($sformatf("vec%0d fetch_err", i), 32'(fetch_err), 32'h0);
    end
    idle_inputs();

    // Ack delayed by four REQ cycles.
`ifdef FETCH_STATS_EN
    stall0 = stall_cnt;
    fetch0 = fetch_cnt;
`endif
    fetch_start = 1'b1;
    pc = 8'h40;
    tick();
    fetch_start = 1'b0;
    check("delay req0", 32'(bus.mem_req), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("delay req%0d", i + 1), 32'(bus.mem_req), 32'h1);
      check($sformatf("delay busy%0d", i + 1), 32'(fetch_busy), 32'h1);
      check($sformatf("delay valid%0d", i + 1), 32'(ir_valid), 32'h0);
    end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'h1234;
    tick();
    idle_inputs();
    check("delay ir", 32'(ir), 32'h1234);
    check("delay ir_valid", 32'(ir_valid), 32'h1);
    check("delay req_drop", 32'(bus.mem_req), 32'h0);
    check("delay jump_instr", 32'(jump_instr), 32'h34);
`ifdef FETCH_STATS_EN
    check("stats stall_cnt", 32'(stall_cnt - stall0), 32'd4);
    check("stats fetch_cnt", 32'(fetch_cnt - fetch0), 32'd1);
`endif

    // Memory never answers: expect a single error pulse 15 cycles after REQ entry.
    fetch_start = 1'b1;
    pc = 8'h50;
    tick();
    fetch_start = 1'b0;
    err_at = 0;
    n = 0;
    while (err_at == 0 && n < 40) begin
      tick();
      n++;
      if (fetch_err) err_at = n;
    end
    check("timeout cycle", 32'(err_at), 32'd15);
    check("timeout ir", 32'(ir), 32'h0);
    check("timeout ir_valid", 32'(ir_valid), 32'h0);
    check("timeout req", 32'(bus.mem_req), 32'h0);
    tick();
    check("timeout err_pulse", 32'(fetch_err), 32'h0);
    fetch_start = 1'b1;
    pc = 8'h51;
    tick();
    fetch_start = 1'b0;
    check("after_timeout addr", 32'(bus.mem_addr), 32'h51);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    tick();
    idle_inputs();
    check("after_timeout ir", 32'(ir), 32'hBEEF);
    check("after_timeout ir_valid", 32'(ir_valid), 32'h1);

    // Asynchronous reset in the middle of a request; ack after release is ignored.
    fetch_start = 1'b1;
    pc = 8'h60;
    tick();
    fetch_start = 1'b0;
    check("midrst req_before", 32'(bus.mem_req), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("midrst req", 32'(bus.mem_req), 32'h0);
    check("midrst addr", 32'(bus.mem_addr), 32'h0);
    check("midrst ir", 32'(ir), 32'h0);
    check("midrst ir_valid", 32'(ir_valid), 32'h0);
    check("midrst busy", 32'(fetch_busy), 32'h0);
    check("midrst jump_instr", 32'(jump_instr), 32'h0);
    tick();
    rst = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'hCAFE;
    tick();
    idle_inputs();
    check("midrst late_ack ir", 32'(ir), 32'h0);
    check("midrst late_ack valid", 32'(ir_valid), 32'h0);
    check("midrst late_ack req", 32'(bus.mem_req), 32'h0);

    // fetch_start held high across three fetches at wrapping addresses.
    fetch_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = addrs[i];
      tick();
      check($sformatf("hold%0d req", i), 32'(bus.mem_req), 32'h1);
      check($sformatf("hold%0d addr", i), 32'(bus.mem_addr), 32'(addrs[i]));
      pc = addrs[i] + 8'h01;
      tick();
      check($sformatf("hold%0d busy_addr", i), 32'(bus.mem_addr), 32'(addrs[i]));
      check($sformatf("hold%0d busy_req", i), 32'(bus.mem_req), 32'h1);
      word = {8'h5A, addrs[i]};
      bus.mem_ack = 1'b1;
      bus.mem_rdata = word;
      tick();
      bus.mem_ack = 1'b0;
      check($sformatf("hold%0d ir", i), 32'(ir), 32'(word));
      check($sformatf("hold%0d valid", i), 32'(ir_valid), 32'h1);
      check($sformatf("hold%0d req_drop", i), 32'(bus.mem_req), 32'h0);
      check($sformatf("hold%0d jump", i), 32'(jump_instr), 32'(addrs[i]));
    end
    idle_inputs();
    tick();
    check("hold no_extra_req", 32'(bus.mem_req), 32'h0);
    check("hold ir_keep", 32'(ir), 32'h5A00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage directly downstream of the program counter. It samples the current 8-bit pc on request and runs a req/ack read against instruction memory. It latches the returned word into the instruction register (IR) and hands the control unit the instruction plus its 8-bit jump target. The program counter consumes that jump target when the control unit asserts its jump-select strobe.

Parameters:
IW, 16, instruction width in bits; must be >= 8
AW, 8, address width; matches the pc width
TIMEOUT, 15, maximum REQ cycles to wait for mem_ack before aborting; range 1..255

Ports:
clk  in  1  clock; block updates on the rising edge (pc changes on the falling edge, so it is stable here)
rst  in  1  reset, asynchronous, active-low
pc  in  AW  current program counter
fetch_start  in  1  control unit requests a fetch of the instruction at pc
flush  in  1  discard the in-flight fetch and the IR contents (jump taken)
mem_addr  out  AW  instruction memory address
mem_req  out  1  memory read request
mem_ack  in  1  memory data valid; single-cycle pulse
mem_rdata  in  IW  memory read data
ir  out  IW  instruction register
ir_valid  out  1  ir holds a fresh instruction
jump_instr  out  AW  ir[AW-1:0]; feeds the pc jump input
fetch_busy  out  1  high while in REQ
fetch_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst=0, async): state=IDLE, mem_addr=0, mem_req=0, ir=0, ir_valid=0, fetch_busy=0, fetch_err=0, timeout counter=0. This applies immediately, including mid-fetch; any pending ack is forgotten.
- State IDLE:
  - fetch_start=1 and flush=0: capture pc into mem_addr, clear ir_valid, clear counter, go to REQ.
  - flush=1: clear ir_valid and stay in IDLE; flush has priority over fetch_start.
- State REQ:
  - mem_req=1 and fetch_busy=1 (both registered from state); mem_addr held constant.
  - mem_ack=1 and flush=0: ir<=mem_rdata, ir_valid<=1, go to IDLE. Latency is fetch_start edge to ir_valid = 2 cycles minimum (1 REQ cycle with same-cycle ack).
  - flush=1, regardless of mem_ack: drop the data, leave ir unchanged, ir_valid=0, go to IDLE. A flush and an ack in the same cycle means the data is lost.
  - No ack: counter increments. When the counter reaches TIMEOUT-1 without an ack, ir<=0 (NOP), ir_valid<=0, fetch_err pulses for 1 cycle, go to IDLE.
  - fetch_start while in REQ is ignored, with no queueing.
- mem_ack received while in IDLE is ignored.
- ir_valid stays 1 until the next accepted fetch_start or a flush. ir holds its value across IDLE.
- jump_instr is combinational from ir[AW-1:0]; its value is 0 after reset.
- Counter width is ceil(log2(TIMEOUT+1)) and it saturates, never wrapping.
- mem_addr takes pc verbatim with no increment; pc=8'hFF is a legal address.

Optional Feature:
FETCH_STATS_EN
- Defined: adds outputs fetch_cnt[15:0] and stall_cnt[15:0], both reset to 0.
  - fetch_cnt increments on each successful IR load.
  - stall_cnt increments on every REQ cycle without mem_ack.
  - Both saturate at 16'hFFFF and are unaffected by flush.
- Not defined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset, then pc=8'h05 with fetch_start for 1 cycle, memory acks 1 cycle later with 16'hA30C -> mem_addr=8'h05, mem_req high for 1 cycle, ir=16'hA30C, ir_valid=1, jump_instr=8'h0C.
- Memory delays ack by 4 cycles with data 16'h1234 -> mem_req and fetch_busy high for 5 cycles, ir_valid rises on the cycle after the ack, stall count 4 under FETCH_STATS_EN.
- TIMEOUT=15 and memory never acks -> fetch_err pulses exactly once, 15 cycles after REQ entry; ir=0, ir_valid=0, state returns to IDLE, and the next fetch_start works.
- flush and mem_ack in the same REQ cycle with data 16'hFFFF -> ir keeps its previous value, ir_valid=0, mem_req drops next cycle.
- rst driven low mid-REQ with mem_ack arriving after release -> all outputs 0 and the ack is ignored.
- fetch_start held high continuously with pc stepping 8'hFE, 8'hFF, 8'h00 -> three fetches at those addresses; fetch_start is ignored while busy, with no extra requests.
